// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB-first, parity, stop; flags parity/framing errors.
// Optional ERR_CNT_EN macro adds a saturating 8-bit error-frame counter output err_cnt_out.
module parity_frame_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              bit_in,
    input  logic              bit_vld_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld_out,
    output logic              par_err_out,
    output logic              frm_err_out,
    output logic              busy_out
`ifdef ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt_out
`endif
);

    localparam int unsigned CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LastBit = CW'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StData, StPar, StStop} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_in;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;
    logic              busy_q;

    // LSB-first reception: new bit enters at the MSB and the word drifts down.
    if (DATA_W == 1) begin : g_shift_one
        assign shift_in = bit_in;
    end else begin : g_shift_multi
        assign shift_in = {bit_in, shift_q[DATA_W-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        if (bit_vld_in) begin
            case (state_q)
                StIdle: begin
                    if (!bit_in) begin
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                        state_d = StData;
                    end
                end
                StData: begin
                    shift_d = shift_in;
                    acc_d   = acc_q ^ bit_in;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LastBit) state_d = StPar;
                end
                StPar: begin
                    acc_d   = acc_q ^ bit_in;
                    state_d = StStop;
                end
                StStop: begin
                    data_d    = shift_q;
                    vld_d     = 1'b1;
                    par_err_d = (acc_q != ODD_PARITY);
                    frm_err_d = ~bit_in;
                    state_d   = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            busy_q    <= (state_d != StIdle);
        end
    end

    assign data_out     = data_q;
    assign data_vld_out = vld_q;
    assign par_err_out  = par_err_q;
    assign frm_err_out  = frm_err_q;
    assign busy_out     = busy_q;

`ifdef ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // A frame with both errors counts once; saturates at 255.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (vld_d && (par_err_d || frm_err_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) err_cnt_q <= 8'd0;
        else           err_cnt_q <= err_cnt_d;
    end

    assign err_cnt_out = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomized self-checking bench for parity_frame_rx: even- and odd-parity instances share one
// bit stream; a frame-level model predicts every output each cycle.
module tb_parity_frame_rx;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_in = 1'b1;
    logic bit_vld = 1'b0;

    logic [W-1:0] data_e, data_o;
    logic vld_e, vld_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
`ifdef ERR_CNT_EN
    logic [7:0] cnt_e, cnt_o;
`endif

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(W), .ODD_PARITY(1'b0)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .bit_in(bit_in), .bit_vld_in(bit_vld),
        .data_out(data_e), .data_vld_out(vld_e), .par_err_out(pe_e), .frm_err_out(fe_e),
        .busy_out(busy_e)
`ifdef ERR_CNT_EN
        , .err_cnt_out(cnt_e)
`endif
    );

    parity_frame_rx #(.DATA_W(W), .ODD_PARITY(1'b1)) dut_odd (
        .clk_in(clk), .rst_n_in(rst_n), .bit_in(bit_in), .bit_vld_in(bit_vld),
        .data_out(data_o), .data_vld_out(vld_o), .par_err_out(pe_o), .frm_err_out(fe_o),
        .busy_out(busy_o)
`ifdef ERR_CNT_EN
        , .err_cnt_out(cnt_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: current expected outputs, plus the result of a frame whose stop bit is being sent.
    logic [W-1:0] m_data = '0;
    logic m_vld = 0, m_pe_e = 0, m_pe_o = 0, m_fe = 0, m_busy = 0;
    int m_cnt_e = 0, m_cnt_o = 0;
    logic p_pend = 0, p_pe_e = 0, p_pe_o = 0, p_fe = 0, p_busy = 0;
    logic [W-1:0] p_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("data_even", 32'(data_e), 32'(m_data));
        chk("data_odd", 32'(data_o), 32'(m_data));
        chk("vld_even", 32'(vld_e), 32'(m_vld));
        chk("vld_odd", 32'(vld_o), 32'(m_vld));
        chk("par_err_even", 32'(pe_e), 32'(m_pe_e));
        chk("par_err_odd", 32'(pe_o), 32'(m_pe_o));
        chk("frm_err_even", 32'(fe_e), 32'(m_fe));
        chk("frm_err_odd", 32'(fe_o), 32'(m_fe));
        chk("busy_even", 32'(busy_e), 32'(m_busy));
        chk("busy_odd", 32'(busy_o), 32'(m_busy));
`ifdef ERR_CNT_EN
        chk("err_cnt_even", 32'(cnt_e), 32'(m_cnt_e));
        chk("err_cnt_odd", 32'(cnt_o), 32'(m_cnt_o));
`endif
    end

    // All stimulus advances through here so the model moves in step with the clock.
    task automatic tick();
        @(posedge clk);
        #1;
        m_vld  = p_pend;
        m_pe_e = p_pend & p_pe_e;
        m_pe_o = p_pend & p_pe_o;
        m_fe   = p_pend & p_fe;
        if (p_pend) begin
            m_data = p_data;
            if ((p_pe_e || p_fe) && m_cnt_e < 255) m_cnt_e++;
            if ((p_pe_o || p_fe) && m_cnt_o < 255) m_cnt_o++;
        end
        p_pend = 1'b0;
        m_busy = p_busy;
    endtask

    task automatic strobe(input logic b);
        bit_in  = b;
        bit_vld = 1'b1;
        tick();
        bit_vld = 1'b0;
        bit_in  = 1'($urandom);
    endtask

    task automatic gap(input int maxgap);
        int n;
        n = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stop,
                              input int maxgap);
        logic x;
        p_busy = 1'b1;
        strobe(1'b0);
        gap(maxgap);
        for (int i = 0; i < W; i++) begin
            strobe(d[i]);
            gap(maxgap);
        end
        strobe(par);
        gap(maxgap);
        x      = (^d) ^ par;
        p_busy = 1'b0;
        p_pend = 1'b1;
        p_data = d;
        p_pe_e = (x != 1'b0);
        p_pe_o = (x != 1'b1);
        p_fe   = ~stop;
        strobe(stop);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        m_data = '0; m_vld = 0; m_pe_e = 0; m_pe_o = 0; m_fe = 0; m_busy = 0;
        m_cnt_e = 0; m_cnt_o = 0;
        p_pend = 0; p_busy = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [W-1:0] d;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1. good A5 frame
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        chk("t1_data", 32'(data_e), 32'hA5);
        chk("t1_vld", 32'(vld_e), 32'd1);
        chk("t1_par", 32'(pe_e), 32'd0);
        chk("t1_frm", 32'(fe_e), 32'd0);
        chk("t1_par_odd", 32'(pe_o), 32'd1);
        tick();
        chk("t1_pulse_end", 32'(vld_e), 32'd0);

        // 2. parity error
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        chk("t2_data", 32'(data_e), 32'hA5);
        chk("t2_par", 32'(pe_e), 32'd1);
        chk("t2_frm", 32'(fe_e), 32'd0);

        // 3. framing error, then idle-line strobe stays idle
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        chk("t3_frm", 32'(fe_e), 32'd1);
        chk("t3_par", 32'(pe_e), 32'd0);
        strobe(1'b1);
        chk("t3_idle", 32'(busy_e), 32'd0);
        gap(2);

        // 4. gaps between strobes
        send_frame(8'h81, 1'b0, 1'b1, 3);
        chk("t4_data", 32'(data_e), 32'h81);
        chk("t4_vld", 32'(vld_e), 32'd1);
        tick();

        // 5. reset mid-frame
        p_busy = 1'b1;
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'(i));
        do_reset();
        chk("t5_data_cleared", 32'(data_e), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        chk("t5_data", 32'(data_e), 32'h3C);

        // Randomized frames, back-to-back or gapped, with occasional idle-line strobes
        for (int f = 0; f < 200; f++) begin
            d = W'($urandom);
            send_frame(d, 1'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) strobe(1'b1);
            gap(int'($urandom_range(0, 1)));
        end

        // 6. saturation: 300 frames of 00 with parity 0 are errors only for odd parity
        do_reset();
        for (int f = 0; f < 300; f++) send_frame(8'h00, 1'b0, 1'b1, 0);
        chk("t6_par_odd", 32'(pe_o), 32'd1);
        chk("t6_par_even", 32'(pe_e), 32'd0);
`ifdef ERR_CNT_EN
        chk("t6_cnt_odd", 32'(cnt_o), 32'd255);
        chk("t6_cnt_even", 32'(cnt_e), 32'd0);
`endif
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
